// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: mode/time-set controller between front-panel keys and the timer
// Inputs : CP clock, CR sync active-high reset, TICK_1K/TICK_1 enables,
//          KEY_MODE/KEY_UP/KEY_DOWN raw keys, Q_H/Q_M/Q_S current BCD time.
// Outputs: CE count enable, PE load pulse, D_H/D_M/D_S BCD presets,
//          SEL edited field, BLINK blank hint, MODE state code.
// Option : CLOCK_SET_AUTOREPEAT_EN enables hold-to-repeat on UP/DOWN.
module clock_set_ctrl #(
  parameter int DEBOUNCE_TICKS = 20,
  parameter int BLINK_DIV      = 250,
  parameter int TIMEOUT_S      = 30
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       TICK_1K,
  input  logic       TICK_1,
  input  logic       KEY_MODE,
  input  logic       KEY_UP,
  input  logic       KEY_DOWN,
  input  logic [7:0] Q_H,
  input  logic [7:0] Q_M,
  input  logic [7:0] Q_S,
  output logic       CE,
  output logic       PE,
  output logic [7:0] D_H,
  output logic [7:0] D_M,
  output logic [7:0] D_S,
  output logic [1:0] SEL,
  output logic       BLINK,
  output logic [2:0] MODE
);
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int BW = $clog2(BLINK_DIV);
  localparam int TW = $clog2(TIMEOUT_S + 1);

  typedef enum logic [2:0] {RUN = 3'd0, SET_H = 3'd1, SET_M = 3'd2, SET_S = 3'd3, COMMIT = 3'd4} state_t;
  state_t state, nxt;

  logic [2:0]    raw, acc, acc_q;
  logic [DW-1:0] db_cnt [3];
  logic [1:0]    rep;
  logic [BW-1:0] blink_cnt;
  logic [TW-1:0] to_cnt;
  logic          mode_ev, up_ev, dn_ev, any_ev, step, in_set, to_hit, blink_clr;

  function automatic logic [7:0] bcd_clamp(input logic [7:0] v, input logic [7:0] mx);
    return (v[3:0] > 4'd9 || v > mx) ? mx : v;
  endfunction

  function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic [7:0] mx, input logic up);
    if (up) return v == mx ? 8'h00 : v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
    return v == 8'h00 ? mx : v[3:0] == 4'd0 ? {v[7:4] - 4'd1, 4'd9} : v - 8'd1;
  endfunction

  assign raw = {KEY_DOWN, KEY_UP, KEY_MODE};

  // Accepted level flips only after DEBOUNCE_TICKS consecutive disagreeing ticks.
  always_ff @(posedge CP)
    for (int i = 0; i < 3; i++)
      if (CR) begin
        db_cnt[i] <= '0;
        acc[i]    <= 1'b0;
        acc_q[i]  <= 1'b0;
      end else begin
        acc_q[i] <= acc[i];
        if (raw[i] == acc[i]) db_cnt[i] <= '0;
        else if (TICK_1K) begin
          db_cnt[i] <= db_cnt[i] == DW'(DEBOUNCE_TICKS - 1) ? '0 : db_cnt[i] + DW'(1);
          acc[i]    <= db_cnt[i] == DW'(DEBOUNCE_TICKS - 1) ? raw[i] : acc[i];
        end
      end

`ifdef CLOCK_SET_AUTOREPEAT_EN
  // First repeat after 500 held ticks, then every 100 (counter reloads to 399).
  logic [9:0] rep_cnt [2];
  always_ff @(posedge CP)
    for (int i = 0; i < 2; i++)
      if (CR || !acc[i+1]) begin
        rep_cnt[i] <= '0;
        rep[i]     <= 1'b0;
      end else begin
        rep[i] <= TICK_1K && rep_cnt[i] == 10'd499;
        if (TICK_1K) rep_cnt[i] <= rep_cnt[i] == 10'd499 ? 10'd399 : rep_cnt[i] + 10'd1;
      end
`else
  assign rep = 2'b00;
`endif

  assign mode_ev   = acc[0] & ~acc_q[0];
  assign up_ev     = (acc[1] & ~acc_q[1]) | rep[0];
  assign dn_ev     = (acc[2] & ~acc_q[2]) | rep[1];
  assign any_ev    = mode_ev | up_ev | dn_ev;
  assign step      = !mode_ev && (up_ev ^ dn_ev);
  assign in_set    = state inside {SET_H, SET_M, SET_S};
  assign to_hit    = in_set && !any_ev && TICK_1 && to_cnt == TW'(TIMEOUT_S - 1);
  assign blink_clr = !(nxt inside {SET_H, SET_M, SET_S}) || nxt != state || up_ev || dn_ev;

  always_comb
    nxt = (state == COMMIT || to_hit) ? RUN :
          mode_ev ? (state == SET_S ? COMMIT : state_t'(state + 3'd1)) : state;

  // Outputs are registered from the next state so they track it edge-for-edge.
  always_ff @(posedge CP)
    if (CR) begin
      state <= RUN;
      CE    <= 1'b1;
      PE    <= 1'b0;
      SEL   <= 2'd0;
      MODE  <= 3'd0;
    end else begin
      state <= nxt;
      CE    <= nxt == RUN;
      PE    <= nxt == COMMIT;
      SEL   <= nxt[1:0];
      MODE  <= nxt;
    end

  always_ff @(posedge CP)
    if (CR) begin
      D_H <= 8'h00;
      D_M <= 8'h00;
      D_S <= 8'h00;
    end else if (state == RUN && mode_ev) begin
      D_H <= bcd_clamp(Q_H, 8'h23);
      D_M <= bcd_clamp(Q_M, 8'h59);
      D_S <= bcd_clamp(Q_S, 8'h59);
    end else if (step) begin
      if (state == SET_H) D_H <= bcd_step(D_H, 8'h23, up_ev);
      if (state == SET_M) D_M <= bcd_step(D_M, 8'h59, up_ev);
      if (state == SET_S) D_S <= bcd_step(D_S, 8'h59, up_ev);
    end

  always_ff @(posedge CP)
    if (CR || !in_set || any_ev || to_hit) to_cnt <= '0;
    else if (TICK_1) to_cnt <= to_cnt + TW'(1);

  always_ff @(posedge CP)
    if (CR || blink_clr) begin
      blink_cnt <= '0;
      BLINK     <= 1'b0;
    end else if (TICK_1K) begin
      blink_cnt <= blink_cnt == BW'(BLINK_DIV - 1) ? '0 : blink_cnt + BW'(1);
      BLINK     <= BLINK ^ (blink_cnt == BW'(BLINK_DIV - 1));
    end
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: self-checking bench for clock_set_ctrl against a transaction-level time-set model
module tb_clock_set_ctrl;
  localparam int DB = 20;
  localparam int BD = 250;
  localparam int TO = 30;

  logic       CP = 0, CR = 1, TICK_1K = 0, TICK_1 = 0;
  logic       KEY_MODE = 0, KEY_UP = 0, KEY_DOWN = 0;
  logic [7:0] Q_H = 0, Q_M = 0, Q_S = 0;
  logic       CE, PE, BLINK;
  logic [7:0] D_H, D_M, D_S;
  logic [1:0] SEL;
  logic [2:0] MODE;

  int         total = 0, bad = 0, pe_cnt = 0;
  logic [7:0] pe_h = 0, pe_m = 0, pe_s = 0;
  int         mode_m = 0, h = 0, m = 0, s = 0;
  bit         blink_m = 0;

  clock_set_ctrl dut (
    .CP(CP), .CR(CR), .TICK_1K(TICK_1K), .TICK_1(TICK_1),
    .KEY_MODE(KEY_MODE), .KEY_UP(KEY_UP), .KEY_DOWN(KEY_DOWN),
    .Q_H(Q_H), .Q_M(Q_M), .Q_S(Q_S),
    .CE(CE), .PE(PE), .D_H(D_H), .D_M(D_M), .D_S(D_S),
    .SEL(SEL), .BLINK(BLINK), .MODE(MODE)
  );

  always #5 CP = ~CP;

  always @(posedge CP)
    if (PE === 1'b1) begin
      pe_cnt <= pe_cnt + 1;
      pe_h   <= D_H;
      pe_m   <= D_M;
      pe_s   <= D_S;
    end

  initial begin
    #1_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic int clampv(input logic [7:0] b, input int mx);
    int v = int'(b[7:4]) * 10 + int'(b[3:0]);
    return (b[3:0] > 9 || b[7:4] > 9 || v > mx) ? mx : v;
  endfunction

  function automatic logic [7:0] i2b(input int v);
    return 8'((v / 10) * 16 + v % 10);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_mode"}, 32'(MODE), 32'(mode_m));
    chk({tag, "_ce"}, 32'(CE), 32'(mode_m == 0));
    chk({tag, "_sel"}, 32'(SEL), 32'((mode_m >= 1 && mode_m <= 3) ? mode_m : 0));
    chk({tag, "_dh"}, 32'(D_H), 32'(i2b(h)));
    chk({tag, "_dm"}, 32'(D_M), 32'(i2b(m)));
    chk({tag, "_ds"}, 32'(D_S), 32'(i2b(s)));
    chk({tag, "_blink"}, 32'(BLINK), 32'(blink_m));
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CP);
      #1;
    end
  endtask

  task automatic tick1k(input int n);
    repeat (n) begin
      TICK_1K = 1;
      cyc(1);
      TICK_1K = 0;
      cyc(1);
    end
  endtask

  task automatic tick1(input int n);
    repeat (n) begin
      TICK_1 = 1;
      cyc(1);
      TICK_1 = 0;
      cyc(1);
    end
  endtask

  task automatic model_reset();
    mode_m = 0; h = 0; m = 0; s = 0; blink_m = 0;
  endtask

  task automatic apply(input bit md, input bit up, input bit dn);
    if (md) begin
      if (mode_m == 0) begin
        h = clampv(Q_H, 23);
        m = clampv(Q_M, 59);
        s = clampv(Q_S, 59);
      end
      mode_m = mode_m == 3 ? 4 : mode_m + 1;
    end else if ((up ^ dn) && mode_m >= 1 && mode_m <= 3) begin
      if (mode_m == 1) h = (h + (up ? 1 : 23)) % 24;
      if (mode_m == 2) m = (m + (up ? 1 : 59)) % 60;
      if (mode_m == 3) s = (s + (up ? 1 : 59)) % 60;
    end
    if (md || up || dn) blink_m = 0;
  endtask

  task automatic press(input bit md, input bit up, input bit dn);
    int pe0 = pe_cnt;
    bit commit;
    KEY_MODE = md; KEY_UP = up; KEY_DOWN = dn;
    tick1k(DB - 1);
    TICK_1K = 1;
    cyc(1);
    TICK_1K = 0;
    chk_all("pre");
    cyc(1);
    apply(md, up, dn);
    commit = mode_m == 4;
    chk_all("evt");
    if (commit) begin
      chk("pe_hi", 32'(PE), 32'd1);
      cyc(1);
      mode_m = 0;
      chk("pe_lo", 32'(PE), 32'd0);
      chk_all("post");
    end
    KEY_MODE = 0; KEY_UP = 0; KEY_DOWN = 0;
    tick1k(DB);
    chk("pe_n", 32'(pe_cnt - pe0), 32'(commit));
  endtask

  initial begin
    int pe0, r;
    cyc(3);
    CR = 0;
    tick1k(30);
    chk_all("reset");
    chk("reset_pe", 32'(PE), 32'd0);
    chk("reset_pecnt", 32'(pe_cnt), 32'd0);

    Q_H = 8'h12; Q_M = 8'h34; Q_S = 8'h56;
    press(1, 0, 0);
    chk("cap_h", 32'(D_H), 32'h12);
    repeat (3) press(0, 0, 1);
    chk("dn3_h", 32'(D_H), 32'h09);
    repeat (3) press(1, 0, 0);
    chk("pe_dh", 32'(pe_h), 32'h09);
    chk("pe_dm", 32'(pe_m), 32'h34);
    chk("pe_ds", 32'(pe_s), 32'h56);

    Q_H = 8'h23; Q_M = 8'h00; Q_S = 8'h59;
    press(1, 0, 0);
    press(0, 1, 0);
    chk("wrap_h", 32'(D_H), 32'h00);
    press(1, 0, 0);
    press(0, 0, 1);
    chk("wrap_m", 32'(D_M), 32'h59);
    press(1, 0, 0);
    press(0, 1, 0);
    chk("wrap_s", 32'(D_S), 32'h00);
    press(1, 0, 0);

    press(1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      KEY_UP = ~KEY_UP;
      tick1k(1);
    end
    KEY_UP = 0;
    cyc(1);
    press(0, 1, 0);
    chk("bounce_h", 32'(D_H), 32'h00);
    press(0, 1, 1);
    chk("both_h", 32'(D_H), 32'h00);
    press(1, 1, 0);
    chk("mode_up_h", 32'(D_H), 32'h00);
    chk("mode_up_mode", 32'(MODE), 32'd2);

    tick1k(BD - DB - 1);
    chk("blink_0", 32'(BLINK), 32'd0);
    tick1k(1);
    chk("blink_1", 32'(BLINK), 32'd1);
    tick1k(BD);
    chk("blink_2", 32'(BLINK), 32'd0);
    tick1k(BD);
    blink_m = 1;
    press(0, 1, 0);

    pe0 = pe_cnt;
    tick1(TO - 1);
    chk_all("to_pre");
    tick1(1);
    mode_m = 0;
    chk_all("to_run");
    chk("to_nope", 32'(pe_cnt - pe0), 32'd0);

    repeat (3) press(1, 0, 0);
    pe0 = pe_cnt;
    CR = 1;
    cyc(1);
    model_reset();
    chk_all("cr_mid");
    CR = 0;
    cyc(2);
    chk("cr_nope", 32'(pe_cnt - pe0), 32'd0);

    Q_H = 8'h00; Q_M = 8'h00; Q_S = 8'h00;
    repeat (3) press(1, 0, 0);
    KEY_UP = 1;
    tick1k(1000);
    KEY_UP = 0;
    tick1k(DB);
`ifdef CLOCK_SET_AUTOREPEAT_EN
    chk("hold_s", 32'(D_S), 32'h06);
`else
    chk("hold_s", 32'(D_S), 32'h01);
`endif
    chk("hold_mode", 32'(MODE), 32'd3);

    CR = 1;
    cyc(1);
    CR = 0;
    model_reset();
    for (int i = 0; i < 40; i++) begin
      if (mode_m == 0) begin
        Q_H = 8'($urandom_range(0, 255));
        Q_M = 8'($urandom_range(0, 255));
        Q_S = 8'($urandom_range(0, 255));
      end
      r = $urandom_range(0, 9);
      press(r <= 2, (r >= 3 && r <= 5) || r == 9, r >= 6);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Mode and time-set controller for the digital clock. Sits between the front-panel keys and the timer, sequencing RUN → set-hour → set-minute → set-second → commit. It gates the timer's count enable and builds BCD preset values. It issues a single synchronous load pulse on commit and drives field-select and blink hints to the display multiplexer.

## Interface
Parameters:
- DEBOUNCE_TICKS, 20, consecutive TICK_1K samples a raw key must hold before its level is accepted
- BLINK_DIV, 250, TICK_1K ticks per BLINK phase
- TIMEOUT_S, 30, idle seconds in a set state before abandoning the edit

Ports:
- CP  in  1  system clock, single clock domain
- CR  in  1  reset, synchronous, active-high
- TICK_1K  in  1  one-CP-cycle enable at 1 kHz
- TICK_1  in  1  one-CP-cycle enable at 1 Hz
- KEY_MODE, KEY_UP, KEY_DOWN  in  1 each  raw keys, active-high, already synchronised to CP
- Q_H, Q_M, Q_S  in  8 each  current BCD time from the timer
- CE  out  1  timer count enable
- PE  out  1  timer synchronous load pulse
- D_H, D_M, D_S  out  8 each  BCD preset values
- SEL  out  2  field being edited: 0 none, 1 hour, 2 minute, 3 second
- BLINK  out  1  1 = blank the selected field
- MODE  out  3  state code

## Operation
- States and MODE codes: RUN=0, SET_H=1, SET_M=2, SET_S=3, COMMIT=4.
- Debounce:
  - Each key has a counter that advances on TICK_1K while raw differs from the accepted level, and clears when they match.
  - On reaching DEBOUNCE_TICKS the accepted level flips.
  - A rising accepted edge produces a one-cycle press event.
- Event priority in one cycle: MODE press beats UP/DOWN. UP and DOWN together are both ignored.
- RUN:
  - CE=1, SEL=0, BLINK=0.
  - MODE press → SET_H, with D_H/D_M/D_S := Q_H/Q_M/Q_S on the same edge.
- SET_H/SET_M/SET_S:
  - CE=0. SEL = 1/2/3.
  - UP/DOWN step the selected D field by ±1 in BCD. Hour wraps 23↔00; minute and second wrap 59↔00. Other fields are unchanged.
  - MODE press advances SET_H → SET_M → SET_S → COMMIT.
- COMMIT:
  - Lasts exactly one cycle: PE=1, CE=0.
  - Next state is RUN with CE=1.
- Timeout:
  - In any SET state, a counter advances on TICK_1 and clears on any press event.
  - When it reaches TIMEOUT_S the block returns to RUN without PE. The edit is discarded and D_* hold their last values.
- Blink:
  - In SET states BLINK toggles every BLINK_DIV TICK_1K ticks.
  - Entering a SET state, or any UP/DOWN event, forces BLINK=0 and clears the blink counter.
- D_* are always valid BCD. An out-of-range capture from Q_* (e.g. hour 0x24) is clamped to the maximum legal value on capture.

## Timing
- All outputs are registered.
- Reset values: CE=1, PE=0, D_H=D_M=D_S=8'h00, SEL=0, BLINK=0, MODE=0 (RUN). All debounce, blink and timeout counters are 0; accepted key levels are 0.
- CR applied mid-edit returns to RUN on the next edge with no PE. CR has priority over every event.
- Press latency: the event fires the CP cycle after the TICK_1K on which the debounce count completes. State, D_* and outputs update on the edge where the event is high, so they are visible one cycle later.
- PE is exactly one CP cycle wide. D_* are stable from at least one cycle before PE until the next MODE press from RUN.
- Timer must sample D_* when PE=1.

## Configuration
- CLOCK_SET_AUTOREPEAT_EN defined:
  - Holding UP or DOWN (accepted level high) for 500 TICK_1K ticks starts repeat events every 100 TICK_1K ticks until release.
  - Each repeat event behaves exactly like a press, including clearing the timeout and blink counters.
- Undefined: exactly one step per accepted rising edge; holding a key has no further effect.

## Test plan
- Reset, then run with no keys → CE=1, PE=0, MODE=0, D_*=00, SEL=0.
- Q=12:34:56, MODE press → MODE=1, CE=0, D=12:34:56, SEL=1. Three DOWN presses on hour → D_H=09. Then MODE×3 → exactly one PE cycle with D=09:34:56, then CE=1, MODE=0.
- Wrap checks: SET_H with D_H=23, UP → 00. SET_M with D_M=00, DOWN → 59. SET_S with D_S=59, UP → 00.
- Key bounce of 5 TICK_1K toggles, then stable high for DEBOUNCE_TICKS → exactly one event. Simultaneous UP+DOWN → D unchanged. MODE+UP in the same cycle → state advances, D unchanged.
- Enter SET_M, idle TIMEOUT_S TICK_1 pulses → RUN, CE=1, no PE. Assert CR in SET_S → RUN next edge, D_*=00, no PE.
- With CLOCK_SET_AUTOREPEAT_EN: hold UP in SET_S from D_S=00 for 1000 TICK_1K → D_S=06 (1 press + 5 repeats). Without the macro → D_S=01.
